// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : Single-word SPI master for the axi2spi_bridge spi_controller
//            slot. A data-register write (EN=1, idle) launches one DATA_W-bit
//            MSB-first transfer using the CPOL/CPHA/CLKDIV captured at start.
// Ports    : FCLK_CLK0, RST           - clock, synchronous active-high reset
//            i_data_to_registers      - register write data
//            i_wr_controll_reg        - write strobe, control register (0x00)
//            i_wr_data_reg            - write strobe, data register (0x08)
//            o_controll_reg           - {CLR=0, CLKDIV, IRQ_EN, CPHA, CPOL, EN}
//            o_status_reg             - {OVR, DONE, BUSY}
//            o_data_reg               - last received word, zero extended
//            IRQ                      - level interrupt, DONE & IRQ_EN
//            i_miso, o_mosi, o_sclk   - SPI pins
//            o_cs_n                   - chip select, only with the macro below
// Option   : SPI_MASTER_CTRL_CS_EN adds o_cs_n and one half period of CS
//            setup before the first SCLK edge.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic        FCLK_CLK0,
  input  logic        RST,
  input  logic [31:0] i_data_to_registers,
  input  logic        i_wr_controll_reg,
  input  logic        i_wr_data_reg,
  output logic [31:0] o_controll_reg,
  output logic [31:0] o_status_reg,
  output logic [31:0] o_data_reg,
  output logic        IRQ,
  input  logic        i_miso,
  output logic        o_mosi,
  output logic        o_sclk
`ifdef SPI_MASTER_CTRL_CS_EN
  ,
  output logic        o_cs_n
`endif
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // control register
  logic             en, cpol, cpha, irq_en;
  logic [DIV_W-1:0] clkdiv;

  // per-transfer copies so control writes during a transfer do not disturb it
  logic             sh_cpol, sh_cpha;
  logic [DIV_W-1:0] sh_div;

  logic [DATA_W-1:0] tx_sr, rx_sr, rx_word;
  logic [DIV_W-1:0]  cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              done_flag, ovr_flag, irq_r, sclk_r, mosi_r;

  logic start, overrun, abort, tick, sclk_tick, leading, last_edge, clr, cpol_nx;
  logic [31:0] ctrl_rb;

`ifdef SPI_MASTER_CTRL_CS_EN
  logic setup, cs_n_r;
`endif

  // start and overrun are qualified by the control value held before this cycle
  assign start    = (state == S_IDLE) && i_wr_data_reg && en;
  assign overrun  = (state == S_XFER) && i_wr_data_reg;
  assign abort    = (state == S_XFER) && i_wr_controll_reg && !i_data_to_registers[0];
  assign tick     = (state == S_XFER) && (cnt == sh_div);
  assign clr      = i_wr_controll_reg && i_data_to_registers[31];
  // idle SCLK level tracks a control write in the same cycle it is stored
  assign cpol_nx  = i_wr_controll_reg ? i_data_to_registers[1] : cpol;
`ifdef SPI_MASTER_CTRL_CS_EN
  // the first tick after start only ends the CS setup half period
  assign sclk_tick = tick && !setup;
`else
  assign sclk_tick = tick;
`endif
  // edge_cnt holds edges already made; the upcoming edge is odd (leading) when it is even
  assign leading   = !edge_cnt[0];
  assign last_edge = sclk_tick && (edge_cnt == LAST_EDGE);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge FCLK_CLK0) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_XFER;
      S_XFER: begin
        if (abort)          state_nx = S_IDLE;
        else if (last_edge) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control register
  // --------------------------------------------------------------------------
  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      en     <= 1'b0;
      cpol   <= 1'b0;
      cpha   <= 1'b0;
      irq_en <= 1'b0;
      clkdiv <= '0;
    end else if (i_wr_controll_reg) begin
      en     <= i_data_to_registers[0];
      cpol   <= i_data_to_registers[1];
      cpha   <= i_data_to_registers[2];
      irq_en <= i_data_to_registers[3];
      clkdiv <= i_data_to_registers[8 +: DIV_W];
    end
  end

  // --------------------------------------------------------------------------
  // Shift engine
  // --------------------------------------------------------------------------
  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      sh_cpol  <= 1'b0;
      sh_cpha  <= 1'b0;
      sh_div   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_word  <= '0;
      cnt      <= '0;
      edge_cnt <= '0;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
`ifdef SPI_MASTER_CTRL_CS_EN
      setup    <= 1'b0;
      cs_n_r   <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          sclk_r <= cpol_nx;
          if (start) begin
            sh_cpol  <= cpol;
            sh_cpha  <= cpha;
            sh_div   <= clkdiv;
            tx_sr    <= i_data_to_registers[DATA_W-1:0];
            rx_sr    <= '0;
            cnt      <= '0;
            edge_cnt <= '0;
            sclk_r   <= cpol;
            // CPHA=0 needs the MSB valid before the first (sampling) edge
            if (!cpha) mosi_r <= i_data_to_registers[DATA_W-1];
`ifdef SPI_MASTER_CTRL_CS_EN
            setup    <= 1'b1;
            cs_n_r   <= 1'b0;
`endif
          end
        end
        S_XFER: begin
          if (abort) begin
            sclk_r <= cpol_nx;
`ifdef SPI_MASTER_CTRL_CS_EN
            cs_n_r <= 1'b1;
`endif
          end else begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
`ifdef SPI_MASTER_CTRL_CS_EN
            if (tick && setup) setup <= 1'b0;
            if (last_edge)     cs_n_r <= 1'b1;
`endif
            if (sclk_tick) begin
              sclk_r   <= ~sclk_r;
              edge_cnt <= edge_cnt + EDGE_W'(1);
              // sample on leading edges for CPHA=0, trailing for CPHA=1
              if (leading ^ sh_cpha) rx_sr <= {rx_sr[DATA_W-2:0], i_miso};
              if (sh_cpha && leading) begin
                mosi_r <= tx_sr[DATA_W-1];
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
              end else if (!sh_cpha && !leading && (edge_cnt != LAST_EDGE)) begin
                mosi_r <= tx_sr[DATA_W-2];
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        S_DONE: begin
          rx_word <= rx_sr;
          sclk_r  <= cpol_nx;
        end
        default: sclk_r <= cpol_nx;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky status flags and interrupt; a set in the same cycle beats CLR
  // --------------------------------------------------------------------------
  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      done_flag <= 1'b0;
      ovr_flag  <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      if (state == S_DONE)  done_flag <= 1'b1;
      else if (start || clr) done_flag <= 1'b0;
      if (overrun)          ovr_flag <= 1'b1;
      else if (clr)         ovr_flag <= 1'b0;
      irq_r <= done_flag && irq_en;
    end
  end

  // --------------------------------------------------------------------------
  // Readback and pins
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_rb             = '0;
    ctrl_rb[0]          = en;
    ctrl_rb[1]          = cpol;
    ctrl_rb[2]          = cpha;
    ctrl_rb[3]          = irq_en;
    ctrl_rb[8 +: DIV_W] = clkdiv;
  end

  assign o_controll_reg = ctrl_rb;
  assign o_status_reg   = {29'd0, ovr_flag, done_flag, (state == S_XFER)};
  assign o_data_reg     = {{(32 - DATA_W){1'b0}}, rx_word};
  assign IRQ            = irq_r;
  assign o_sclk         = sclk_r;
  assign o_mosi         = mosi_r;
`ifdef SPI_MASTER_CTRL_CS_EN
  assign o_cs_n         = cs_n_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Purpose  : Self-checking bench for spi_master_ctrl (DATA_W=8, DIV_W=8).
//            Expected receive words are queued at each start and compared
//            when the transfer completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

`ifdef SPI_MASTER_CTRL_CS_EN
  localparam int CS_HP = 1;
`else
  localparam int CS_HP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        wr_ctrl = 1'b0;
  logic        wr_data = 1'b0;
  logic [31:0] ctrl_rb, status_rb, data_rb;
  logic        irq, mosi, sclk, miso;
  logic        lb = 1'b0;
  logic        miso_drv = 1'b0;
`ifdef SPI_MASTER_CTRL_CS_EN
  logic        cs_n;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rx = '0;

  assign miso = lb ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_W(8), .DIV_W(8)) dut (
    .FCLK_CLK0           (clk),
    .RST                 (rst),
    .i_data_to_registers (data_in),
    .i_wr_controll_reg   (wr_ctrl),
    .i_wr_data_reg       (wr_data),
    .o_controll_reg      (ctrl_rb),
    .o_status_reg        (status_rb),
    .o_data_reg          (data_rb),
    .IRQ                 (irq),
    .i_miso              (miso),
    .o_mosi              (mosi),
    .o_sclk              (sclk)
`ifdef SPI_MASTER_CTRL_CS_EN
    ,
    .o_cs_n              (cs_n)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_ctrl(input logic [31:0] val);
    @(negedge clk);
    data_in = val;
    wr_ctrl = 1'b1;
    @(negedge clk);
    wr_ctrl = 1'b0;
  endtask

  // One complete transfer; optionally injects a second data write while busy.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] pat, input bit loop,
                          input bit cpha, input int div, input int ovr_at,
                          input logic [7:0] ovr_data, input logic [31:0] exp_status,
                          input logic exp_irq);
    int busy_n, edges, guard, cs_low;
    logic prev;
    logic [7:0] mseq;
    logic [31:0] exp_rx;
    busy_n = 0; edges = 0; guard = 0; cs_low = 0; mseq = '0;
    lb = loop;
    miso_drv = 1'b0;
    exp_q.push_back(loop ? {24'h0, tx} : {24'h0, pat});
    @(negedge clk);
    prev    = sclk;
    data_in = {24'h0, tx};
    wr_data = 1'b1;
    @(negedge clk);
    wr_data = 1'b0;
    while (guard < 500) begin
      if (sclk !== prev) begin
        edges++;
        prev = sclk;
        if ((edges % 2 == 1) && !loop && edges < 16) miso_drv = pat[7 - (edges - 1) / 2];
        if (((edges % 2 == 1) != cpha) && edges <= 16) mseq[7 - (edges - 1) / 2] = mosi;
      end
      if (status_rb[0] !== 1'b1) break;
      busy_n++;
`ifdef SPI_MASTER_CTRL_CS_EN
      if (cs_n === 1'b0) cs_low++;
`endif
      if (busy_n == ovr_at) data_in = {24'h0, ovr_data};
      wr_data = (busy_n == ovr_at);
      @(negedge clk);
      guard++;
    end
    wr_data = 1'b0;
    chk("xfer_in_time", (guard < 500) ? 32'd1 : 32'd0, 32'd1);
    chk("busy_cycles", busy_n, (16 + CS_HP) * (div + 1));
    chk("sclk_edges", edges, 16);
    chk("mosi_bits", {24'h0, mseq}, {24'h0, tx});
`ifdef SPI_MASTER_CTRL_CS_EN
    chk("cs_low_cycles", cs_low, (16 + CS_HP) * (div + 1));
`endif
    @(negedge clk);
    @(negedge clk);
    chk("status_done", status_rb, exp_status);
    exp_rx = exp_q.pop_front();
    chk("rx_data", data_rb, exp_rx);
    last_rx = exp_rx;
    chk("irq", {31'd0, irq}, {31'd0, exp_irq});
  endtask

  initial begin
    int edges, guard;
    logic prev;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", ctrl_rb, 32'h0);
    chk("rst_status", status_rb, 32'h0);
    chk("rst_data", data_rb, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_sclk", {31'd0, sclk}, 32'h0);
    chk("rst_mosi", {31'd0, mosi}, 32'h0);
    rst = 1'b0;

    // ---- data write with EN=0 is ignored
    @(negedge clk);
    data_in = 32'h55;
    wr_data = 1'b1;
    @(negedge clk);
    wr_data = 1'b0;
    repeat (4) @(negedge clk);
    chk("en0_status", status_rb, 32'h0);
    chk("en0_sclk", {31'd0, sclk}, 32'h0);

    // ---- mode 0 loopback, CLKDIV=1, IRQ enabled
    write_ctrl(32'h0000_0109);
    chk("ctrl_rb", ctrl_rb, 32'h0000_0109);
    run_xfer(8'hA5, 8'h00, 1'b1, 1'b0, 1, 0, 8'h00, 32'h2, 1'b1);

    // ---- CLR reads back as 0 and clears DONE and IRQ
    write_ctrl(32'h8000_0109);
    chk("ctrl_clr_rb", ctrl_rb, 32'h0000_0109);
    @(negedge clk);
    chk("clr_status", status_rb, 32'h0);
    chk("clr_irq", {31'd0, irq}, 32'h0);

    // ---- mode 3, CLKDIV=0, MISO driven on leading edges
    write_ctrl(32'h0000_0007);
    chk("mode3_idle_sclk", {31'd0, sclk}, 32'h1);
    run_xfer(8'h3C, 8'hC3, 1'b0, 1'b1, 0, 0, 8'h00, 32'h2, 1'b0);

    // ---- overrun: second write while busy is dropped and flagged
    write_ctrl(32'h0000_0109);
    run_xfer(8'h11, 8'h00, 1'b1, 1'b0, 1, 4, 8'h22, 32'h6, 1'b1);
    write_ctrl(32'h8000_0109);
    @(negedge clk);
    chk("ovr_clr_status", status_rb, 32'h0);
    chk("ovr_clr_irq", {31'd0, irq}, 32'h0);

    // ---- abort with EN=0, CPOL=1 mid-transfer
    write_ctrl(32'h0000_010B);
    lb = 1'b1;
    @(negedge clk);
    data_in = 32'h5A;
    wr_data = 1'b1;
    @(negedge clk);
    wr_data = 1'b0;
    repeat (5) @(negedge clk);
    data_in = 32'h0000_010A;
    wr_ctrl = 1'b1;
    @(negedge clk);
    wr_ctrl = 1'b0;
    chk("abort_status", status_rb, 32'h0);
    chk("abort_sclk", {31'd0, sclk}, 32'h1);
    chk("abort_data", data_rb, last_rx);
    repeat (3) @(negedge clk);
    chk("abort_no_done", status_rb, 32'h0);
    write_ctrl(32'h0000_0109);
    chk("post_abort_sclk", {31'd0, sclk}, 32'h0);
    run_xfer(8'h96, 8'h00, 1'b1, 1'b0, 1, 0, 8'h00, 32'h2, 1'b1);

    // ---- reset asserted at SCLK edge 5
    lb = 1'b1;
    @(negedge clk);
    prev    = sclk;
    data_in = 32'hF0;
    wr_data = 1'b1;
    @(negedge clk);
    wr_data = 1'b0;
    edges = 0;
    guard = 0;
    while (edges < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (sclk !== prev) begin
        edges++;
        prev = sclk;
      end
    end
    chk("rst_edge_reached", edges, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl", ctrl_rb, 32'h0);
    chk("midrst_status", status_rb, 32'h0);
    chk("midrst_data", data_rb, 32'h0);
    chk("midrst_irq", {31'd0, irq}, 32'h0);
    chk("midrst_sclk", {31'd0, sclk}, 32'h0);
    chk("midrst_mosi", {31'd0, mosi}, 32'h0);
`ifdef SPI_MASTER_CTRL_CS_EN
    chk("midrst_cs_n", {31'd0, cs_n}, 32'h1);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-byte SPI master controller that fills the spi_controller slot of axi2spi_bridge.
- Consumes the register-write strobes and data from axi_interface: control register at offset 0x00, data register at offset 0x08.
- Returns control, status and data readback words to axi_interface, drives the SPI pins, and raises IRQ to the AXI master on completion.
- Each transfer is started by a write to the data register and is configurable in CPOL, CPHA and SCLK divider.

Parameters:
DATA_W, 8, bits per transfer, MSB first; legal range 2..24
DIV_W, 8, width of control field CLKDIV

Ports:
FCLK_CLK0  in  1  clock
RST  in  1  synchronous reset, active-high
i_data_to_registers  in  32  write data from axi_interface
i_wr_controll_reg  in  1  1-cycle write strobe, control reg (0x00)
i_wr_data_reg  in  1  1-cycle write strobe, data reg (0x08)
o_controll_reg  out  32  control readback
o_status_reg  out  32  status readback
o_data_reg  out  32  {zeros, last received word}
IRQ  out  1  level interrupt
i_miso  in  1  SPI MISO
o_mosi  out  1  SPI MOSI
o_sclk  out  1  SPI clock

Behaviour:
- Control register fields: [0] EN; [1] CPOL; [2] CPHA; [3] IRQ_EN; [8+DIV_W-1:8] CLKDIV; [31] CLR (write-1 clears DONE and OVR, always reads 0). All other bits read 0.
- Status register fields: [0] BUSY; [1] DONE (sticky); [2] OVR (sticky). All other bits 0.
- Reset: all registers 0. Outputs o_sclk=0, o_mosi=0, IRQ=0, all readbacks 0. FSM in IDLE.
- FSM states: IDLE, XFER, DONE.
- Start: in IDLE, i_wr_data_reg=1 with EN=1 (value held before this cycle). Effects:
  - latch CPOL/CPHA/CLKDIV into shadow registers;
  - load i_data_to_registers[DATA_W-1:0] into the tx shift register;
  - clear DONE; set BUSY; cnt=0, edge=0; go to XFER.
  - CPHA=0: o_mosi = bit DATA_W-1 from the next cycle.
- Write to the data reg while EN=0: ignored, no flag set.
- Write to the data reg while BUSY: data ignored, OVR set, the current transfer is unaffected.
- XFER timing:
  - cnt increments each cycle; when cnt==CLKDIV, an edge tick occurs: cnt<=0, o_sclk toggles, edge increments.
  - Half period = CLKDIV+1 cycles; CLKDIV=0 is legal (SCLK = FCLK/2).
  - Odd-numbered edges (1,3,...) are leading edges; even-numbered edges are trailing edges.
  - CPHA=0: sample i_miso on leading edges; shift the next bit onto o_mosi on trailing edges, except after the final edge.
  - CPHA=1: drive the next bit (MSB first) onto o_mosi on leading edges; sample on trailing edges.
  - Sampling shifts i_miso into the LSB of the rx register.
- End of transfer: after edge 2*DATA_W, o_sclk has returned to CPOL; go to DONE.
  - Transfer length, from the start cycle to entering DONE: 2*DATA_W*(CLKDIV+1) cycles.
- DONE (1 cycle): rx copied to the data readback; BUSY=0; DONE=1; next state IDLE. o_mosi holds its last value.
- IRQ = DONE & IRQ_EN, registered. It clears on a CLR write, on the next start, or when IRQ_EN=0.
- o_sclk in IDLE follows the control CPOL bit, updated the cycle after the control write.
- Control write during XFER: CPOL/CPHA/CLKDIV changes take effect only at the next start, because the transfer uses the shadow copies.
  - Writing EN=0 during XFER aborts: next cycle state=IDLE, BUSY=0, o_sclk=CPOL, DONE not set, data readback unchanged.
- Simultaneous events in one cycle:
  - DONE-set and CLR: set wins.
  - OVR-set and CLR: set wins.
  - Control write and data write: the data write is qualified by the old control value, and the new control value is stored.
- RST asserted mid-transfer: reset values on the next edge, no completion.

Optional Feature:
- Macro: SPI_MASTER_CTRL_CS_EN.
- Defined: adds output port o_cs_n (1 bit, reset 1).
  - o_cs_n goes low in the start cycle+1, together with BUSY.
  - It returns high in the DONE cycle, or on abort.
  - One extra half period (CLKDIV+1 cycles) of CS setup is inserted before edge 1, so transfer length becomes (2*DATA_W+1)*(CLKDIV+1).
- Undefined: port absent, timing exactly as in Behaviour.

Test Plan:
- Mode 0, loopback: CLKDIV=1, CPOL=0, CPHA=0, IRQ_EN=1, i_miso tied to o_mosi; write data 0xA5.
  → BUSY for 32 cycles; o_sclk toggles every 2 cycles (16 edges); data readback 0x000000A5; DONE=1, IRQ=1.
- Mode 3: CPOL=1, CPHA=1, CLKDIV=0, tx 0x3C, bench drives MISO 0xC3 on leading edges.
  → o_sclk idles 1; rx 0xC3; o_mosi bit sequence 0,0,1,1,1,1,0,0 seen at trailing edges.
- Overrun: write 0x11 then 0x22 during BUSY.
  → transfer sends 0x11; OVR=1; write control with CLR=1 → status 0x0, IRQ=0.
- Abort: mid-transfer write control EN=0.
  → next cycle BUSY=0, o_sclk=CPOL, DONE=0, data readback unchanged; a later start with EN=1 works normally.
- Edge cases:
  - data write with EN=0 → no activity, status 0;
  - RST asserted at edge 5 → all outputs at reset values next cycle;
  - with SPI_MASTER_CTRL_CS_EN, CLKDIV=1 → o_cs_n low for 34 cycles.
